// File: rtl/rx_arb_pkg.sv
// Shared types and default sizing for the receive-stream arbiter.
package rx_arb_pkg;

   localparam int DEF_WIDTH  = 10;
   localparam int DEF_NUM_CH = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin requester search: first set request after the pointer, wrapping.
module rr_pick
   import rx_arb_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int ID_W   = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [ID_W-1:0]   ptr_i,
   output logic              found_o,
   output logic [ID_W-1:0]   idx_o
);

   logic [ID_W-1:0] cand;

   // Scan ptr+1, ptr+2, ... ptr+NUM_CH (the pointer itself has lowest priority).
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      cand    = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         cand = ID_W'((int'(ptr_i) + k) % NUM_CH);
         if (!found_o && req_i[cand]) begin
            found_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/rx_stream_arb.sv
// Packet-locked round-robin merge of NUM_CH upstream streams into one
// registered downstream stream, with a delivered-packet counter.
module rx_stream_arb
   import rx_arb_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int ID_W   = $clog2(NUM_CH)
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic [NUM_CH*WIDTH-1:0] DATA_UP,
   input  logic [NUM_CH-1:0]       VALID_UP,
   input  logic [NUM_CH-1:0]       LAST_UP,
   output logic [NUM_CH-1:0]       READY_UP,
   output logic [WIDTH-1:0]        DATA_DOWN,
   output logic                    LAST_DOWN,
   output logic [ID_W-1:0]         ID_DOWN,
   output logic                    VALID_DOWN,
   input  logic                    READY_DOWN,
   output logic [7:0]              PKT_CNT
);

   state_e          state_q, state_d;
   logic [ID_W-1:0] gnt_q, gnt_d;
   logic [ID_W-1:0] ptr_q, ptr_d;
   logic            vld_q;
   logic [WIDTH-1:0] data_q;
   logic            last_q;
   logic [ID_W-1:0] id_q;
   logic [7:0]      cnt_q;

   logic             pick_found;
   logic [ID_W-1:0]  pick_idx;
   logic             slot_free;
   logic             accept;
   logic             accept_last;
   logic             drain;
   logic [WIDTH-1:0] up_data [NUM_CH];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
      assign up_data[i] = DATA_UP[i*WIDTH +: WIDTH];
   end

   // Output register can take a beat when empty or being drained this cycle.
   assign slot_free   = !vld_q || READY_DOWN;
   assign accept      = (state_q == BUSY) && VALID_UP[gnt_q] && slot_free;
   assign accept_last = accept && LAST_UP[gnt_q];
   assign drain       = vld_q && READY_DOWN;

   rr_pick #(
      .NUM_CH (NUM_CH),
      .ID_W   (ID_W)
   ) u_pick (
      .req_i   (VALID_UP),
      .ptr_i   (ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   // FSM state, grant and round-robin pointer registers.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ptr_q   <= ID_W'(NUM_CH - 1);
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
      end
   end

   // Next state: grant from IDLE, hold the lock until the LAST beat is taken.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = BUSY;
               gnt_d   = pick_idx;
            end
         end
         BUSY: begin
            if (accept_last) begin
               state_d = IDLE;
               ptr_d   = gnt_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Upstream ready goes only to the locked channel, and only while busy.
   always_comb begin
      READY_UP = '0;
      if (state_q == BUSY) begin
         READY_UP[gnt_q] = slot_free;
      end
   end

   // Output register: load on accept, hold on stall, empty after a drain.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         vld_q  <= 1'b0;
         data_q <= '0;
         last_q <= 1'b0;
         id_q   <= '0;
      end else if (accept) begin
         vld_q  <= 1'b1;
         data_q <= up_data[gnt_q];
         last_q <= LAST_UP[gnt_q];
         id_q   <= gnt_q;
      end else if (drain) begin
         vld_q  <= 1'b0;
      end
   end

   // Count packets whose final beat has left downstream.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt_q <= '0;
      end else if (drain && last_q) begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   assign VALID_DOWN = vld_q;
   assign DATA_DOWN  = data_q;
   assign LAST_DOWN  = last_q;
   assign ID_DOWN    = id_q;
   assign PKT_CNT    = cnt_q;

endmodule

// File: tb/tb_rx_stream_arb.sv
// Randomized and directed bench for rx_stream_arb with a cycle reference model.
module tb_rx_stream_arb;

   localparam int W  = 10;
   localparam int N  = 4;
   localparam int IW = 2;

   logic           CLK = 1'b0;
   logic           RESET = 1'b1;
   logic [N*W-1:0] DATA_UP = '0;
   logic [N-1:0]   VALID_UP = '0;
   logic [N-1:0]   LAST_UP = '0;
   logic [N-1:0]   READY_UP;
   logic [W-1:0]   DATA_DOWN;
   logic           LAST_DOWN;
   logic [IW-1:0]  ID_DOWN;
   logic           VALID_DOWN;
   logic           READY_DOWN = 1'b0;
   logic [7:0]     PKT_CNT;

   int errors = 0;
   int checks = 0;

   rx_stream_arb #(.WIDTH(W), .NUM_CH(N), .ID_W(IW)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .DATA_UP    (DATA_UP),
      .VALID_UP   (VALID_UP),
      .LAST_UP    (LAST_UP),
      .READY_UP   (READY_UP),
      .DATA_DOWN  (DATA_DOWN),
      .LAST_DOWN  (LAST_DOWN),
      .ID_DOWN    (ID_DOWN),
      .VALID_DOWN (VALID_DOWN),
      .READY_DOWN (READY_DOWN),
      .PKT_CNT    (PKT_CNT)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: who owns the output, where the search starts,
   // what the output slot holds and how many packets were delivered.
   int           m_owner = -1;
   int           m_ptr = N - 1;
   bit           m_ov = 0;
   bit           m_ol = 0;
   logic [W-1:0] m_od = '0;
   int           m_oi = 0;
   int           m_cnt = 0;
   int           cyc = 0;
   int           dq[$];
   int           dq_t[$];

   always @(negedge CLK) begin : compare
      logic [N-1:0] exp_rdy;
      bit acc, drn;
      int c;
      #2;
      cyc++;
      if (RESET) begin
         chk("rst_valid", VALID_DOWN, 0);
         chk("rst_data", DATA_DOWN, 0);
         chk("rst_last", LAST_DOWN, 0);
         chk("rst_id", ID_DOWN, 0);
         chk("rst_cnt", PKT_CNT, 0);
         chk("rst_ready", READY_UP, 0);
         m_owner = -1; m_ptr = N - 1; m_ov = 0; m_ol = 0; m_od = '0; m_oi = 0; m_cnt = 0;
      end else begin
         exp_rdy = '0;
         if (m_owner >= 0 && (!m_ov || READY_DOWN)) exp_rdy[m_owner] = 1'b1;
         chk("ready_up", READY_UP, exp_rdy);
         chk("valid_down", VALID_DOWN, m_ov);
         if (m_ov) begin
            chk("data_down", DATA_DOWN, m_od);
            chk("last_down", LAST_DOWN, m_ol);
            chk("id_down", ID_DOWN, m_oi);
         end
         chk("pkt_cnt", PKT_CNT, m_cnt);
         if (VALID_DOWN && READY_DOWN) begin
            dq.push_back(int'(ID_DOWN));
            dq_t.push_back(cyc);
         end
         drn = m_ov && READY_DOWN;
         acc = (exp_rdy != 0) && VALID_UP[m_owner];
         if (drn && m_ol) m_cnt = (m_cnt + 1) % 256;
         if (acc) begin
            m_od = DATA_UP[m_owner*W +: W];
            m_ol = LAST_UP[m_owner];
            m_oi = m_owner;
            m_ov = 1;
         end else if (drn) begin
            m_ov = 0;
         end
         if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
               c = (m_ptr + k) % N;
               if (VALID_UP[c]) begin
                  m_owner = c;
                  break;
               end
            end
         end else if (acc && LAST_UP[m_owner]) begin
            m_ptr   = m_owner;
            m_owner = -1;
         end
      end
   end

   // Upstream sources: rem[c] beats left in channel c's current packet.
   int rem[N];

   task automatic clear_rem();
      for (int c = 0; c < N; c++) rem[c] = 0;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET = 1'b1; VALID_UP = '0; LAST_UP = '0;
      clear_rem();
      @(negedge CLK);
      RESET = 1'b0;
      dq.delete(); dq_t.delete();
   endtask

   // refill: 0 none, 1 single-beat packets forever, 2 random new packets.
   task automatic cycle_src(input int p_valid, input int p_ready, input int refill);
      @(negedge CLK);
      for (int c = 0; c < N; c++) begin
         if (refill == 2 && rem[c] == 0 && $urandom_range(0, 9) == 0)
            rem[c] = $urandom_range(1, 4);
         VALID_UP[c] = (rem[c] > 0) && ($urandom_range(0, 99) < p_valid);
         LAST_UP[c]  = (rem[c] == 1);
         DATA_UP[c*W +: W] = W'($urandom);
      end
      READY_DOWN = ($urandom_range(0, 99) < p_ready);
      #1;
      for (int c = 0; c < N; c++) begin
         if (VALID_UP[c] && READY_UP[c]) begin
            rem[c]--;
            if (rem[c] == 0 && refill == 1) rem[c] = 1;
         end
      end
   endtask

   function automatic int dq_at(input int i);
      return (i < dq.size()) ? dq[i] : -1;
   endfunction

   function automatic int dqt_at(input int i);
      return (i < dq_t.size()) ? dq_t[i] : -100;
   endfunction

   initial begin : main
      logic [W-1:0] held;
      bit seen128;
      clear_rem();
      repeat (2) @(negedge CLK);

      // Single one-beat packet on channel 0.
      do_reset();
      @(negedge CLK);
      VALID_UP = 4'b0001; LAST_UP = 4'b0001; DATA_UP[0 +: W] = 10'h155; READY_DOWN = 1'b1;
      @(negedge CLK); #3;
      chk("one_ready0", READY_UP, 4'b0001);
      @(negedge CLK);
      VALID_UP = '0; LAST_UP = '0;
      #3;
      chk("one_valid", VALID_DOWN, 1);
      chk("one_data", DATA_DOWN, 10'h155);
      chk("one_id", ID_DOWN, 0);
      @(negedge CLK); #3;
      chk("one_cnt", PKT_CNT, 1);

      // All channels requesting single-beat packets.
      do_reset();
      for (int c = 0; c < N; c++) rem[c] = 1;
      repeat (12) cycle_src(100, 100, 1);
      chk("rr_g0", dq_at(0), 0);
      chk("rr_g1", dq_at(1), 1);
      chk("rr_g2", dq_at(2), 2);
      chk("rr_g3", dq_at(3), 3);
      chk("rr_g4", dq_at(4), 0);
      for (int i = 0; i < 4; i++) chk("rr_gap", dqt_at(i + 1) - dqt_at(i), 2);

      // Channel 2 owns a 3-beat packet while channel 1 waits.
      do_reset();
      rem[2] = 3;
      cycle_src(100, 100, 0);
      rem[1] = 1;
      repeat (10) cycle_src(100, 100, 0);
      chk("lock_n", dq.size(), 4);
      chk("lock_b0", dq_at(0), 2);
      chk("lock_b1", dq_at(1), 2);
      chk("lock_b2", dq_at(2), 2);
      chk("lock_next", dq_at(3), 1);
      chk("lock_contig1", dqt_at(1) - dqt_at(0), 1);
      chk("lock_contig2", dqt_at(2) - dqt_at(1), 1);

      // Downstream stall for 5 cycles.
      do_reset();
      rem[0] = 3;
      repeat (2) cycle_src(100, 100, 0);
      held = '0;
      for (int i = 0; i < 5; i++) begin
         cycle_src(100, 0, 0);
         chk("stall_valid", VALID_DOWN, 1);
         chk("stall_ready", READY_UP, 0);
         if (i == 0) held = DATA_DOWN;
         else chk("stall_data", DATA_DOWN, held);
      end
      repeat (10) cycle_src(100, 100, 0);
      chk("stall_beats", dq.size(), 3);

      // Reset in the middle of a 4-beat packet.
      do_reset();
      rem[0] = 4;
      for (int i = 0; i < 20; i++) begin
         cycle_src(100, 100, 0);
         if (dq.size() >= 2) break;
      end
      chk("mid_reached", dq.size() >= 2, 1);
      @(negedge CLK);
      RESET = 1'b1; VALID_UP = '0; LAST_UP = '0;
      clear_rem();
      #3;
      chk("mid_valid", VALID_DOWN, 0);
      chk("mid_cnt", PKT_CNT, 0);
      @(negedge CLK);
      RESET = 1'b0;
      dq.delete(); dq_t.delete();
      rem[0] = 1; rem[1] = 1;
      repeat (10) cycle_src(100, 100, 0);
      chk("mid_n", dq.size(), 2);
      chk("mid_first", dq_at(0), 0);
      chk("mid_second", dq_at(1), 1);

      // 256 packets wrap the counter.
      do_reset();
      rem[0] = 1;
      seen128 = 0;
      for (int i = 0; i < 1200; i++) begin
         cycle_src(100, 100, 1);
         if (dq.size() == 128 && !seen128) begin
            seen128 = 1;
            chk("wrap_half", PKT_CNT, 128);
         end
         if (dq.size() >= 256) break;
      end
      chk("wrap_n", dq.size(), 256);
      chk("wrap_cnt", PKT_CNT, 0);
      clear_rem();

      // Random traffic with a reset partway through.
      do_reset();
      for (int c = 0; c < N; c++) rem[c] = $urandom_range(1, 4);
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            do_reset();
            for (int c = 0; c < N; c++) rem[c] = $urandom_range(1, 4);
         end
         cycle_src(80, 70, 2);
      end

      @(negedge CLK);
      VALID_UP = '0;
      repeat (2) @(negedge CLK);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
